// File: rtl/complex_op_pkg.sv
// Shared definitions for the complex_op encoder/decoder path: default width,
// decoder FSM states and the golden encoder function.
package complex_op_pkg;

  localparam int COMPLEX_OP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cod_state_t;

  // Golden encoder: code = (d1 | d2) + d2, wrapping mod 2^WIDTH.
  function automatic logic [COMPLEX_OP_WIDTH-1:0] complex_op_ref(
    input logic [COMPLEX_OP_WIDTH-1:0] d1,
    input logic [COMPLEX_OP_WIDTH-1:0] d2
  );
    return (d1 | d2) + d2;
  endfunction

endpackage

// File: rtl/complex_op_decoder_if.sv
// Valid/ready bundle between an encoded-word source and the complex_op decoder.
interface complex_op_decoder_if
  import complex_op_pkg::*;
#(
  parameter int WIDTH = COMPLEX_OP_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] code_in;
  logic [WIDTH-1:0] key_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] mask_out;
  logic             err_out;

  modport master (
    output in_valid, code_in, key_in, out_ready,
    input  in_ready, out_valid, data_out, mask_out, err_out
  );

  modport slave (
    input  in_valid, code_in, key_in, out_ready,
    output in_ready, out_valid, data_out, mask_out, err_out
  );

endinterface

// File: rtl/complex_op_decoder.sv
// Bit-serial decoder for code = (d1 | d2) + d2: subtracts the key one bit per
// cycle, LSB first, recovering d1 & ~key and flagging codes no d1 could produce.
module complex_op_decoder
  import complex_op_pkg::*;
#(
  parameter  int WIDTH = COMPLEX_OP_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  complex_op_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  cod_state_t       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] mask_out_q, mask_out_d;
  logic             err_out_q, err_out_d;

  logic in_ready;
  logic code_bit, key_bit, diff_bit, borrow_next;

  assign in_ready = (state_q == IDLE) && rst_n;

  // One full-subtractor cell: code[i] - key[i] - borrow.
  assign code_bit    = code_q[idx_q];
  assign key_bit     = key_q[idx_q];
  assign diff_bit    = code_bit ^ key_bit ^ borrow_q;
  assign borrow_next = (~code_bit & (key_bit | borrow_q)) | (key_bit & borrow_q);

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    borrow_d   = borrow_q;
    code_d     = code_q;
    key_d      = key_q;
    data_d     = data_q;
    err_d      = err_q;
    data_out_d = data_out_q;
    mask_out_d = mask_out_q;
    err_out_d  = err_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          code_d   = bus.code_in;
          key_d    = bus.key_in;
          idx_d    = '0;
          borrow_d = 1'b0;
          data_d   = '0;
          err_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        data_d[idx_q] = diff_bit & ~key_bit;
        err_d         = err_q | (key_bit & ~diff_bit);
        borrow_d      = borrow_next;
        idx_d         = idx_q + 1'b1;
        // The final borrow is simply dropped: that is the mod 2^WIDTH wrap.
        if (idx_q == LAST_IDX) begin
          data_out_d = data_d;
          mask_out_d = ~key_q;
          err_out_d  = err_d;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      code_q     <= '0;
      key_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      mask_out_q <= '0;
      err_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      borrow_q   <= borrow_d;
      code_q     <= code_d;
      key_q      <= key_d;
      data_q     <= data_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      mask_out_q <= mask_out_d;
      err_out_q  <= err_out_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = data_out_q;
  assign bus.mask_out  = mask_out_q;
  assign bus.err_out   = err_out_q;

endmodule

// File: tb/tb_complex_op_decoder.sv
// Scoreboard bench for complex_op_decoder: the driver queues the expected
// response at each accept, an independent monitor checks every output handshake.
module tb_complex_op_decoder;
  import complex_op_pkg::*;

  localparam int W = COMPLEX_OP_WIDTH;

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] mask;
    logic         err;
  } resp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  complex_op_decoder_if #(.WIDTH(W)) bus ();

  complex_op_decoder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    accept_edge = 0;
  int    n_sent = 0;
  int    n_recv = 0;
  int    ready_mode = 0;  // 0: always ready, 1: random stalls, 2: held low
  resp_t sb_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic resp_t mk(input logic [W-1:0] data, input logic [W-1:0] mask,
                               input logic err);
    mk = '{data: data, mask: mask, err: err};
  endfunction

  // Downstream ready, updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every output handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'(sb_q.size()), 32'd1);
      end else begin
        resp_t exp;
        exp = sb_q.pop_front();
        check("data_out", bus.data_out, exp.data);
        check("mask_out", bus.mask_out, exp.mask);
        check("err_out", bus.err_out, exp.err);
        n_recv++;
      end
    end
  end

  task automatic send(input logic [W-1:0] code, input logic [W-1:0] key, input resp_t exp);
    int t;
    @(negedge clk);
    bus.code_in  = code;
    bus.key_in   = key;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    if (bus.in_ready) begin
      sb_q.push_back(exp);
      n_sent++;
      accept_edge = cyc + 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", bus.out_valid, 1'b1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.code_in  = '0;
    bus.key_in   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_data_out", bus.data_out, 16'h0000);
    check("rst_mask_out", bus.mask_out, 16'h0000);
    check("rst_err_out", bus.err_out, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1'b1);

    // Basic decode plus latency: valid in the 17th cycle counted from the accept edge
    send(16'h13E4, 16'h00F0, mk(16'h1204, 16'hFF0F, 1'b0));
    wait_out_valid();
    check("latency_cycles", 32'(cyc - accept_edge + 1), 32'(W + 1));
    drain();

    // Wrap-around, zero key, invalid code, all-ones key
    send(16'h0000, 16'h0001, mk(16'hFFFE, 16'hFFFE, 1'b0));
    send(16'hABCD, 16'h0000, mk(16'hABCD, 16'hFFFF, 1'b0));
    send(16'h0002, 16'h0002, mk(16'h0000, 16'hFFFD, 1'b1));
    send(16'hFFFE, 16'hFFFF, mk(16'h0000, 16'h0000, 1'b0));
    send(16'h0000, 16'hFFFF, mk(16'h0000, 16'h0000, 1'b1));
    drain();

    // Backpressure with a second input held pending
    ready_mode = 2;
    send(16'h13E4, 16'h00F0, mk(16'h1204, 16'hFF0F, 1'b0));
    @(negedge clk);
    bus.code_in  = 16'h0000;
    bus.key_in   = 16'h0001;
    bus.in_valid = 1'b1;
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_data_out", bus.data_out, 16'h1204);
      check("stall_mask_out", bus.mask_out, 16'hFF0F);
      check("stall_err_out", bus.err_out, 1'b0);
      @(negedge clk);
    end
    check("stall_pending_not_consumed", 32'(sb_q.size()), 32'd1);
    ready_mode = 0;
    send(16'h0000, 16'h0001, mk(16'hFFFE, 16'hFFFE, 1'b0));
    drain();

    // Reset in the 7th RUN cycle
    send(16'h13E4, 16'h00F0, mk(16'h1204, 16'hFF0F, 1'b0));
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b0);
    check("abort_data_out", bus.data_out, 16'h0000);
    check("abort_mask_out", bus.mask_out, 16'h0000);
    check("abort_err_out", bus.err_out, 1'b0);
    void'(sb_q.pop_back());
    n_sent--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_in_ready", bus.in_ready, 1'b1);
    check("post_abort_out_valid", bus.out_valid, 1'b0);
    send(16'h13E4, 16'h00F0, mk(16'h1204, 16'hFF0F, 1'b0));
    drain();

    // Random encoded words with random downstream stalls
    ready_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] d1, d2;
      d1 = W'($urandom);
      d2 = W'($urandom);
      send(complex_op_ref(d1, d2), d2, mk(d1 & ~d2, ~d2, 1'b0));
    end
    drain();
    ready_mode = 0;

    check("response_count", 32'(n_recv), 32'(n_sent));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
